// File: rtl/coffee_machine_controller.sv
// Credit-accumulating coffee vending controller; all outputs registered, latency 1, coins bypassed when busy or full.
// Define COFFEE_AUTO_CHANGE_EN to return leftover credit automatically after each dispense.
module coffee_machine_controller #(
   parameter int PRICE       = 100,
   parameter int MAX_CREDIT  = 300,
   parameter int DISP_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic fifty,
   input  logic hundred,
   input  logic coff_out_req,
   input  logic coin_ret_req,
   output logic bypass,
   output logic coff_out,
   output logic coin_ret
);

   localparam int MAX_U = MAX_CREDIT / 50;
   localparam int CW    = $clog2(MAX_U + 1);
   localparam int CNTW  = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [CW-1:0] PRICE_U = CW'(PRICE / 50);
   localparam logic [CW:0]   MAX_UW  = (CW+1)'(MAX_U);

   typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_RETURN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   credit_q, credit_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            bypass_q, bypass_d;
   logic            coff_out_q, coff_out_d;
   logic            coin_ret_q, coin_ret_d;

   logic            acted;
   logic            coin_any;
   logic            coin_ok;
   logic [CW:0]     coin_units;
   logic [CW:0]     sum;

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      cnt_d      = cnt_q;
      bypass_d   = 1'b0;
      coff_out_d = 1'b0;
      coin_ret_d = 1'b0;
      acted      = 1'b0;
      coin_any   = fifty | hundred;
      coin_ok    = fifty ^ hundred;
      coin_units = (CW+1)'(hundred ? 2 : 1);
      sum        = {1'b0, credit_q} + coin_units;

      case (state_q)
         S_IDLE, S_CREDIT: begin
            if (coin_ret_req && credit_q != '0) begin
               state_d    = S_RETURN;
               coin_ret_d = 1'b1;
               credit_d   = '0;
               acted      = 1'b1;
            end else if (coff_out_req && credit_q >= PRICE_U) begin
               state_d    = S_DISPENSE;
               credit_d   = credit_q - PRICE_U;
               coff_out_d = 1'b1;
               cnt_d      = CNTW'(DISP_CYCLES - 1);
               acted      = 1'b1;
            end
            // A coin competes with any request that was acted on; the request wins.
            if (coin_any) begin
               if (!acted && coin_ok && sum <= MAX_UW) begin
                  credit_d = sum[CW-1:0];
                  state_d  = S_CREDIT;
               end else begin
                  bypass_d = 1'b1;
               end
            end
         end
         S_DISPENSE: begin
            bypass_d = coin_any;
            if (cnt_q != '0) begin
               coff_out_d = 1'b1;
               cnt_d      = cnt_q - 1'b1;
            end else begin
`ifdef COFFEE_AUTO_CHANGE_EN
               if (credit_q != '0) begin
                  state_d    = S_RETURN;
                  coin_ret_d = 1'b1;
                  credit_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
`else
               state_d = (credit_q != '0) ? S_CREDIT : S_IDLE;
`endif
            end
         end
         S_RETURN: begin
            bypass_d = coin_any;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         credit_q   <= '0;
         cnt_q      <= '0;
         bypass_q   <= 1'b0;
         coff_out_q <= 1'b0;
         coin_ret_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         cnt_q      <= cnt_d;
         bypass_q   <= bypass_d;
         coff_out_q <= coff_out_d;
         coin_ret_q <= coin_ret_d;
      end
   end

   assign bypass   = bypass_q;
   assign coff_out = coff_out_q;
   assign coin_ret = coin_ret_q;

endmodule

// File: tb/tb_coffee_machine_controller.sv
// Directed bench for coffee_machine_controller; expected {bypass,coff_out,coin_ret} queued per driven cycle.
module tb_coffee_machine_controller;

   logic clk = 1'b0;
   logic reset;
   logic fifty, hundred, coff_out_req, coin_ret_req;
   logic bypass, coff_out, coin_ret;

   int total = 0;
   int bad   = 0;
   logic [2:0] expq[$];

   coffee_machine_controller #(.PRICE(100), .MAX_CREDIT(300), .DISP_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .fifty        (fifty),
      .hundred      (hundred),
      .coff_out_req (coff_out_req),
      .coin_ret_req (coin_ret_req),
      .bypass       (bypass),
      .coff_out     (coff_out),
      .coin_ret     (coin_ret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: {bypass,coff_out,coin_ret} got %b expected %b", tag, obs, exp_v);
      end
   endtask

   // One clock of stimulus (f, h, coffee req, return req); expected outputs after the edge.
   task automatic cyc(input string tag, input logic f, input logic h, input logic cr,
                      input logic rr, input logic [2:0] e);
      fifty        = f;
      hundred      = h;
      coff_out_req = cr;
      coin_ret_req = rr;
      expq.push_back(e);
      @(posedge clk);
      #1;
      fifty        = 1'b0;
      hundred      = 1'b0;
      coff_out_req = 1'b0;
      coin_ret_req = 1'b0;
      chk(tag, {bypass, coff_out, coin_ret}, expq.pop_front());
   endtask

   initial begin
      reset = 1'b1;
      fifty = 1'b0; hundred = 1'b0; coff_out_req = 1'b0; coin_ret_req = 1'b0;
      #12;
      chk("reset", {bypass, coff_out, coin_ret}, 3'b000);
      @(negedge clk);
      reset = 1'b0;

      cyc("ret_zero",     0, 0, 0, 1, 3'b000);
      cyc("idle",         0, 0, 0, 0, 3'b000);
      cyc("fifty_in",     1, 0, 0, 0, 3'b000);
      cyc("ret_pulse",    0, 0, 0, 1, 3'b001);
      cyc("ret_end",      0, 0, 0, 0, 3'b000);
      cyc("ret_cleared",  0, 0, 0, 1, 3'b000);

      cyc("coff_zero",    0, 0, 1, 0, 3'b000);
      cyc("hundred_in",   0, 1, 0, 0, 3'b000);
      cyc("disp_c1",      0, 0, 1, 0, 3'b010);
      cyc("disp_c2",      0, 0, 0, 0, 3'b010);
      cyc("disp_c3",      0, 0, 0, 0, 3'b010);
      cyc("disp_c4",      0, 0, 0, 0, 3'b010);
      cyc("disp_off",     0, 0, 0, 0, 3'b000);
      cyc("disp_idle",    0, 0, 0, 1, 3'b000);

      cyc("max_h1",       0, 1, 0, 0, 3'b000);
      cyc("max_h2",       0, 1, 0, 0, 3'b000);
      cyc("max_h3",       0, 1, 0, 0, 3'b000);
      cyc("over_fifty",   1, 0, 0, 0, 3'b100);
      cyc("over_hundred", 0, 1, 0, 0, 3'b100);
      cyc("over_gap",     0, 0, 0, 0, 3'b000);
      cyc("ret_max",      0, 0, 0, 1, 3'b001);
      cyc("ret_max_end",  0, 0, 0, 0, 3'b000);

      cyc("both_coins",   1, 1, 0, 0, 3'b100);
      cyc("both_nocred",  0, 0, 0, 1, 3'b000);
      cyc("h_for_disp",   0, 1, 0, 0, 3'b000);
      cyc("disp2_c1",     0, 0, 1, 0, 3'b010);
      cyc("coin_in_disp", 1, 0, 0, 0, 3'b110);
      cyc("disp2_c3",     0, 0, 0, 0, 3'b010);
      cyc("disp2_c4",     0, 0, 0, 0, 3'b010);
      cyc("disp2_off",    0, 0, 0, 0, 3'b000);
      cyc("disp_coin_lost", 0, 0, 0, 1, 3'b000);

      cyc("prio_h",       0, 1, 0, 0, 3'b000);
      cyc("prio_f",       1, 0, 0, 0, 3'b000);
      cyc("prio_all",     1, 0, 1, 1, 3'b101);
      cyc("prio_end",     0, 0, 0, 0, 3'b000);
      cyc("prio_noret",   0, 0, 0, 1, 3'b000);
      cyc("prio_nocoff",  0, 0, 1, 0, 3'b000);

      cyc("ign_req_f1",   1, 0, 1, 0, 3'b000);
      cyc("ign_req_f2",   1, 0, 1, 0, 3'b000);
      cyc("disp3_c1",     0, 0, 1, 0, 3'b010);
      cyc("disp3_c2",     0, 0, 0, 0, 3'b010);
      cyc("disp3_c3",     0, 0, 0, 0, 3'b010);
      cyc("disp3_c4",     0, 0, 0, 0, 3'b010);
      cyc("disp3_off",    0, 0, 0, 0, 3'b000);
      cyc("disp3_empty",  0, 0, 0, 1, 3'b000);

      cyc("chg_h",        0, 1, 0, 0, 3'b000);
      cyc("chg_f",        1, 0, 0, 0, 3'b000);
      cyc("chg_c1",       0, 0, 1, 0, 3'b010);
      cyc("chg_c2",       0, 0, 0, 0, 3'b010);
      cyc("chg_c3",       0, 0, 0, 0, 3'b010);
      cyc("chg_c4",       0, 0, 0, 0, 3'b010);
`ifdef COFFEE_AUTO_CHANGE_EN
      cyc("chg_auto_ret", 0, 0, 0, 0, 3'b001);
      cyc("chg_auto_end", 0, 0, 0, 0, 3'b000);
      cyc("chg_auto_none", 0, 0, 0, 1, 3'b000);
`else
      cyc("chg_keep",     0, 0, 0, 0, 3'b000);
      cyc("chg_low_coff", 0, 0, 1, 0, 3'b000);
      cyc("chg_left_ret", 0, 0, 0, 1, 3'b001);
      cyc("chg_left_end", 0, 0, 0, 0, 3'b000);
`endif

      cyc("rst_h1",       0, 1, 0, 0, 3'b000);
      cyc("rst_h2",       0, 1, 0, 0, 3'b000);
      cyc("rst_disp",     0, 0, 1, 0, 3'b010);
      reset = 1'b1;
      #2;
      chk("rst_async", {bypass, coff_out, coin_ret}, 3'b000);
      reset = 1'b0;
      cyc("rst_lost_ret", 0, 0, 0, 1, 3'b000);
      cyc("rst_lost_coff", 0, 0, 1, 0, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
